// File: rtl/brick_game_ctrl.sv
// Frame-rate brick game sequencer: steers the board, drops bricks and scores catches.
// Every game update lands on the vsync falling edge so a frame never shows a half update.
module brick_game_ctrl #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned BOARD_W    = 64,
    parameter int unsigned BOARD_Y    = 464,
    parameter int unsigned BRICK_SIZE = 50,
    parameter int unsigned BOARD_STEP = 4,
    parameter int unsigned BRICK_STEP = 2,
    parameter logic [9:0]  LFSR_SEED  = 10'h001
) (
    input  logic       dclk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [9:0] board_x,
    output logic [9:0] board_y,
    output logic [9:0] brick_x,
    output logic [9:0] brick_y,
    output logic [7:0] score,
    output logic       game_over,
    output logic [1:0] state
);
    typedef enum logic [1:0] {StIdle = 2'd0, StFall = 2'd1, StOver = 2'd2} state_e;

    localparam logic [10:0] BoardXMax  = 11'(SCREEN_W - BOARD_W);
    localparam logic [9:0]  BoardXInit = 10'((SCREEN_W - BOARD_W) / 2);
    localparam logic [9:0]  BrickXInit = 10'((SCREEN_W - BRICK_SIZE) / 2);
    localparam logic [9:0]  SpawnRange = 10'(SCREEN_W - BRICK_SIZE);
    localparam logic [9:0]  BrickYLand = 10'(BOARD_Y - BRICK_SIZE);
    localparam logic [10:0] BoardStep  = 11'(BOARD_STEP);
    localparam logic [10:0] BrickStep  = 11'(BRICK_STEP);
    localparam logic [10:0] BrickSize  = 11'(BRICK_SIZE);
    localparam logic [10:0] BoardW     = 11'(BOARD_W);
    localparam logic [10:0] BoardY     = 11'(BOARD_Y);

    if (BOARD_Y >= SCREEN_H || BRICK_SIZE >= BOARD_Y) begin : g_bad_geometry
        $error("brick_game_ctrl: board row must lie inside the active area");
    end

    state_e      state_q, state_d;
    logic        vsync_q;
    logic [9:0]  lfsr_q;
    logic [9:0]  board_x_q, board_x_d;
    logic [9:0]  brick_x_q, brick_x_d;
    logic [9:0]  brick_y_q, brick_y_d;
    logic [7:0]  score_q, score_d;
    logic        game_over_q, game_over_d;
    logic        tick, land, hit;
    logic [9:0]  spawn_x;
    logic [10:0] bx_cur, nbx, ny, bk_x;

    assign tick    = vsync_q & ~vsync;
    // Folding the upper LFSR range back keeps every spawn fully on screen.
    assign spawn_x = (lfsr_q < SpawnRange) ? lfsr_q : lfsr_q - SpawnRange;
    assign bx_cur  = {1'b0, board_x_q};
    assign bk_x    = {1'b0, brick_x_q};
    assign ny      = {1'b0, brick_y_q} + BrickStep;
    assign land    = (ny + BrickSize) >= BoardY;
    assign hit     = (bk_x < nbx + BoardW) && (bk_x + BrickSize > nbx);

    always_comb begin
        nbx = bx_cur;
        if (btn_left && !btn_right) begin
            nbx = (bx_cur >= BoardStep) ? bx_cur - BoardStep : '0;
        end else if (btn_right && !btn_left) begin
            nbx = (bx_cur + BoardStep > BoardXMax) ? BoardXMax : bx_cur + BoardStep;
        end
    end

    always_comb begin
        state_d     = state_q;
        board_x_d   = board_x_q;
        brick_x_d   = brick_x_q;
        brick_y_d   = brick_y_q;
        score_d     = score_q;
        game_over_d = game_over_q;
        case (state_q)
            StIdle: begin
                if (btn_start) begin
                    state_d   = StFall;
                    score_d   = '0;
                    brick_y_d = '0;
                    brick_x_d = spawn_x;
                    board_x_d = BoardXInit;
                end
            end
            StFall: begin
                if (tick) begin
                    board_x_d = nbx[9:0];
                    if (!land) begin
                        brick_y_d = ny[9:0];
                    end else if (hit) begin
                        score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        brick_y_d = '0;
                        brick_x_d = spawn_x;
                    end else begin
                        brick_y_d   = BrickYLand;
                        game_over_d = 1'b1;
                        state_d     = StOver;
                    end
                end
            end
            StOver: begin
                if (btn_start) begin
                    state_d     = StIdle;
                    game_over_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            lfsr_q      <= LFSR_SEED;
            state_q     <= StIdle;
            board_x_q   <= BoardXInit;
            brick_x_q   <= BrickXInit;
            brick_y_q   <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            lfsr_q      <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
            state_q     <= state_d;
            board_x_q   <= board_x_d;
            brick_x_q   <= brick_x_d;
            brick_y_q   <= brick_y_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
        end
    end

    assign board_x   = board_x_q;
    assign board_y   = 10'(BOARD_Y);
    assign brick_x   = brick_x_q;
    assign brick_y   = brick_y_q;
    assign score     = score_q;
    assign game_over = game_over_q;
    assign state     = state_q;

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Directed bench for brick_game_ctrl: board steering, clamping, catch/miss, saturation, reset.
module tb_brick_game_ctrl;
    logic       dclk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_start = 1'b0;
    logic [9:0] board_x, board_y, brick_x, brick_y;
    logic [7:0] score;
    logic       game_over;
    logic [1:0] state;

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] m_lfsr;
    logic [9:0] pre_lfsr;
    int         exp_bx;
    int         exp_bk;

    brick_game_ctrl dut (
        .dclk      (dclk),
        .rst       (rst),
        .vsync     (vsync),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_start (btn_start),
        .board_x   (board_x),
        .board_y   (board_y),
        .brick_x   (brick_x),
        .brick_y   (brick_y),
        .score     (score),
        .game_over (game_over),
        .state     (state)
    );

    always #20 dclk = ~dclk;

    // Reference x^10+x^7+1 sequence, used only to predict spawn positions.
    always @(posedge dclk) begin
        if (rst) m_lfsr <= 10'h001;
        else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    function automatic int spawn(input logic [9:0] l);
        return (int'(l) < 590) ? int'(l) : int'(l) - 590;
    endfunction

    task automatic do_reset();
        rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0; vsync = 1'b1;
        repeat (3) @(negedge dclk);
        rst = 1'b0;
    endtask

    task automatic frame(input logic l, input logic r);
        btn_left = l; btn_right = r; vsync = 1'b0;
        pre_lfsr = m_lfsr;
        @(negedge dclk);
        vsync = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
        @(negedge dclk);
    endtask

    task automatic start_game();
        btn_start = 1'b1;
        pre_lfsr = m_lfsr;
        @(negedge dclk);
        btn_start = 1'b0;
        exp_bk = spawn(pre_lfsr);
        exp_bx = 288;
    endtask

    // Steer into the catch window (aim=1) or drive to the far side of the brick (aim=0).
    task automatic steer(input int n, input logic aim);
        logic l, r;
        for (int i = 0; i < n; i++) begin
            l = 1'b0; r = 1'b0;
            if (aim) begin
                if (exp_bk >= exp_bx + 64)      r = 1'b1;
                else if (exp_bk + 50 <= exp_bx) l = 1'b1;
            end else begin
                if (exp_bk >= 288) l = 1'b1;
                else               r = 1'b1;
            end
            if (l) exp_bx = (exp_bx < 4) ? 0 : exp_bx - 4;
            if (r) exp_bx = (exp_bx + 4 > 576) ? 576 : exp_bx + 4;
            frame(l, r);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (board_x !== 10'd288) begin miscompares++;
            $display("FAIL reset_board_x: got %0d want 288", board_x); end
        vectors++; if (board_y !== 10'd464) begin miscompares++;
            $display("FAIL reset_board_y: got %0d want 464", board_y); end
        vectors++; if (brick_x !== 10'd295 || brick_y !== 10'd0) begin miscompares++;
            $display("FAIL reset_brick: got %0d,%0d want 295,0", brick_x, brick_y); end
        vectors++; if (score !== 8'd0 || state !== 2'd0 || game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got s=%0d st=%0d go=%0d want 0,0,0",
                     score, state, game_over); end
        repeat (10) @(negedge dclk);
        vectors++; if (board_x !== 10'd288 || brick_y !== 10'd0 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got bx=%0d by=%0d st=%0d want 288,0,0",
                     board_x, brick_y, state); end
    endtask

    task automatic test_board_move();
        do_reset();
        start_game();
        vectors++; if (state !== 2'd1 || brick_y !== 10'd0 || board_x !== 10'd288) begin
            miscompares++;
            $display("FAIL start: got st=%0d by=%0d bx=%0d want 1,0,288",
                     state, brick_y, board_x); end
        vectors++; if (int'(brick_x) != exp_bk) begin miscompares++;
            $display("FAIL start_spawn: got %0d want %0d", brick_x, exp_bk); end
        repeat (10) frame(1'b0, 1'b1);
        vectors++; if (board_x !== 10'd328 || brick_y !== 10'd20) begin miscompares++;
            $display("FAIL move_right: got bx=%0d by=%0d want 328,20", board_x, brick_y); end
        repeat (5) frame(1'b1, 1'b1);
        vectors++; if (board_x !== 10'd328 || brick_y !== 10'd30) begin miscompares++;
            $display("FAIL move_both: got bx=%0d by=%0d want 328,30", board_x, brick_y); end
        btn_start = 1'b1;
        @(negedge dclk);
        btn_start = 1'b0;
        vectors++; if (state !== 2'd1 || brick_y !== 10'd30 || score !== 8'd0) begin
            miscompares++;
            $display("FAIL start_in_fall: got st=%0d by=%0d want 1,30", state, brick_y); end
    endtask

    task automatic test_board_clamp();
        do_reset();
        start_game();
        repeat (71) frame(1'b1, 1'b0);
        vectors++; if (board_x !== 10'd4 || brick_y !== 10'd142) begin miscompares++;
            $display("FAIL left_to_4: got bx=%0d by=%0d want 4,142", board_x, brick_y); end
        repeat (3) frame(1'b1, 1'b0);
        vectors++; if (board_x !== 10'd0) begin miscompares++;
            $display("FAIL left_clamp: got %0d want 0", board_x); end
        do_reset();
        start_game();
        repeat (71) frame(1'b0, 1'b1);
        vectors++; if (board_x !== 10'd572) begin miscompares++;
            $display("FAIL right_to_572: got %0d want 572", board_x); end
        repeat (2) frame(1'b0, 1'b1);
        vectors++; if (board_x !== 10'd576 || brick_y !== 10'd146) begin miscompares++;
            $display("FAIL right_clamp: got bx=%0d by=%0d want 576,146", board_x, brick_y); end
    endtask

    task automatic test_catch();
        do_reset();
        start_game();
        steer(206, 1'b1);
        vectors++; if (brick_y !== 10'd412 || state !== 2'd1 || score !== 8'd0) begin
            miscompares++;
            $display("FAIL pre_land: got by=%0d st=%0d s=%0d want 412,1,0",
                     brick_y, state, score); end
        vectors++; if (int'(board_x) != exp_bx) begin miscompares++;
            $display("FAIL steer_board: got %0d want %0d", board_x, exp_bx); end
        steer(1, 1'b1);
        exp_bk = spawn(pre_lfsr);
        vectors++; if (score !== 8'd1 || brick_y !== 10'd0 || state !== 2'd1) begin
            miscompares++;
            $display("FAIL catch: got s=%0d by=%0d st=%0d want 1,0,1", score, brick_y, state); end
        vectors++; if (int'(brick_x) != exp_bk || brick_x >= 10'd590) begin miscompares++;
            $display("FAIL catch_spawn: got %0d want %0d", brick_x, exp_bk); end
        force dut.score_q = 8'hFF;
        @(negedge dclk);
        release dut.score_q;
        @(negedge dclk);
        steer(207, 1'b1);
        exp_bk = spawn(pre_lfsr);
        vectors++; if (score !== 8'd255 || brick_y !== 10'd0 || state !== 2'd1) begin
            miscompares++;
            $display("FAIL score_sat: got s=%0d by=%0d want 255,0", score, brick_y); end
    endtask

    task automatic test_reset_mid_fall();
        repeat (2) frame(1'b0, 1'b1);
        rst = 1'b1; btn_start = 1'b1; vsync = 1'b0;
        @(negedge dclk);
        vectors++; if (board_x !== 10'd288 || brick_x !== 10'd295 || brick_y !== 10'd0) begin
            miscompares++;
            $display("FAIL midrst_pos: got %0d,%0d,%0d want 288,295,0",
                     board_x, brick_x, brick_y); end
        vectors++; if (score !== 8'd0 || state !== 2'd0 || game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: got s=%0d st=%0d want 0,0", score, state); end
        rst = 1'b0; btn_start = 1'b0; vsync = 1'b1;
        repeat (2) @(negedge dclk);
        vectors++; if (state !== 2'd0 || brick_y !== 10'd0) begin miscompares++;
            $display("FAIL midrst_after: got st=%0d by=%0d want 0,0", state, brick_y); end
    endtask

    task automatic test_miss_over();
        int bx_hold;
        do_reset();
        start_game();
        steer(207, 1'b1);
        exp_bk = spawn(pre_lfsr);
        steer(206, 1'b0);
        vectors++; if (brick_y !== 10'd412 || score !== 8'd1) begin miscompares++;
            $display("FAIL pre_miss: got by=%0d s=%0d want 412,1", brick_y, score); end
        steer(1, 1'b0);
        vectors++; if (brick_y !== 10'd414 || game_over !== 1'b1 || state !== 2'd2) begin
            miscompares++;
            $display("FAIL miss: got by=%0d go=%0d st=%0d want 414,1,2",
                     brick_y, game_over, state); end
        bx_hold = int'(board_x);
        frame(1'b1, 1'b0);
        vectors++; if (int'(board_x) != bx_hold || brick_y !== 10'd414 || score !== 8'd1) begin
            miscompares++;
            $display("FAIL over_hold: got bx=%0d by=%0d want %0d,414", board_x, brick_y,
                     bx_hold); end
        btn_start = 1'b1;
        @(negedge dclk);
        btn_start = 1'b0;
        vectors++; if (state !== 2'd0 || game_over !== 1'b0 || score !== 8'd1) begin
            miscompares++;
            $display("FAIL over_exit: got st=%0d go=%0d s=%0d want 0,0,1",
                     state, game_over, score); end
        frame(1'b0, 1'b1);
        vectors++; if (state !== 2'd0 || brick_y !== 10'd414 || int'(board_x) != bx_hold) begin
            miscompares++;
            $display("FAIL idle_hold: got st=%0d by=%0d want 0,414", state, brick_y); end
        start_game();
        vectors++; if (state !== 2'd1 || score !== 8'd0 || brick_y !== 10'd0
                       || board_x !== 10'd288 || int'(brick_x) != exp_bk) begin
            miscompares++;
            $display("FAIL restart: got st=%0d s=%0d by=%0d bx=%0d kx=%0d want 1,0,0,288,%0d",
                     state, score, brick_y, board_x, brick_x, exp_bk); end
    endtask

    initial begin
        test_reset();
        test_board_move();
        test_board_clamp();
        test_catch();
        test_reset_mid_fall();
        test_miss_over();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
